clint_ctrl: RTL and testbench

//  Core-local interrupt/exception sequencer between id/ex and the CSR file.

---
 rtl/clint_ctrl.sv | 151 +++++++++++++++
 tb/tb_clint_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/clint_ctrl.sv
// Core-local interrupt/exception sequencer: stalls the pipeline, writes mepc/mstatus/mcause, redirects fetch.
// Optional feature: define CLINT_EBREAK_EN to decode ebreak as a synchronous trap (mcause 3).
module clint_ctrl #(
  parameter int          INT_NUM     = 8,
  parameter logic [31:0] CAUSE_TIMER = 32'h80000007,
  parameter logic [31:0] CAUSE_EXT   = 32'h8000000B
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INT_NUM-1:0] int_flag_i,
  input  logic [31:0]        inst_i,
  input  logic [31:0]        inst_addr_i,
  input  logic               jump_flag_i,
  input  logic [31:0]        jump_addr_i,
  input  logic               div_started_i,
  input  logic               global_int_en_i,
  input  logic [31:0]        csr_mtvec_i,
  input  logic [31:0]        csr_mepc_i,
  input  logic [31:0]        csr_mstatus_i,
  output logic               hold_flag_o,
  output logic               we_o,
  output logic [31:0]        waddr_o,
  output logic [31:0]        data_o,
  output logic               int_assert_o,
  output logic [31:0]        int_addr_o
);

  // state       | meaning
  // S_IDLE      | watching for ecall/ebreak/mret/interrupt
  // S_W_MEPC    | writing saved pc to mepc
  // S_W_MSTATUS | writing mstatus (MPIE<=MIE, MIE<=0)
  // S_W_MCAUSE  | writing saved cause, redirect to mtvec
  // S_W_MRET    | writing mstatus (MIE<=MPIE, MPIE<=1), redirect to mepc
  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MSTATUS,
    S_W_MCAUSE,
    S_W_MRET
  } state_t;

  localparam logic [31:0] INST_ECALL  = 32'h00000073;
  localparam logic [31:0] INST_EBREAK = 32'h00100073;
  localparam logic [31:0] INST_MRET   = 32'h30200073;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_cause;
  logic [31:0] r_pc;

  logic        w_ecall;
  logic        w_ebreak;
  logic        w_mret;
  logic        w_sync;
  logic        w_async;
  logic [31:0] w_sync_cause;
  logic [31:0] w_async_cause;
  logic [31:0] w_async_pc;

  assign w_ecall = (inst_i == INST_ECALL);
`ifdef CLINT_EBREAK_EN
  assign w_ebreak = (inst_i == INST_EBREAK);
`else
  assign w_ebreak = 1'b0;
`endif
  assign w_mret        = (inst_i == INST_MRET);
  assign w_sync        = w_ecall | w_ebreak;
  assign w_async       = (|int_flag_i) & global_int_en_i & ~div_started_i;
  assign w_sync_cause  = w_ecall ? 32'd11 : 32'd3;
  assign w_async_cause = int_flag_i[0] ? CAUSE_TIMER : CAUSE_EXT;
  assign w_async_pc    = jump_flag_i ? jump_addr_i : inst_addr_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cause <= 32'h0;
      r_pc    <= 32'h0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        if (w_sync) begin
          r_cause <= w_sync_cause;
          r_pc    <= inst_addr_i;
        end else if (!w_mret && w_async) begin
          r_cause <= w_async_cause;
          r_pc    <= w_async_pc;
        end
      end
    end
  end

  // An mret stalls only during its single CSR-write cycle; traps also stall in the detect cycle.
  always_comb begin
    w_next       = r_state;
    hold_flag_o  = 1'b0;
    we_o         = 1'b0;
    waddr_o      = 32'h0;
    data_o       = 32'h0;
    int_assert_o = 1'b0;
    int_addr_o   = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (w_sync) begin
          w_next      = S_W_MEPC;
          hold_flag_o = 1'b1;
        end else if (w_mret) begin
          w_next = S_W_MRET;
        end else if (w_async) begin
          w_next      = S_W_MEPC;
          hold_flag_o = 1'b1;
        end
      end
      S_W_MEPC: begin
        hold_flag_o = 1'b1;
        we_o        = 1'b1;
        waddr_o     = {20'h0, 12'h341};
        data_o      = r_pc;
        w_next      = S_W_MSTATUS;
      end
      S_W_MSTATUS: begin
        hold_flag_o = 1'b1;
        we_o        = 1'b1;
        waddr_o     = {20'h0, 12'h300};
        data_o      = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4],
                       1'b0, csr_mstatus_i[2:0]};
        w_next      = S_W_MCAUSE;
      end
      S_W_MCAUSE: begin
        hold_flag_o  = 1'b1;
        we_o         = 1'b1;
        waddr_o      = {20'h0, 12'h342};
        data_o       = r_cause;
        int_assert_o = 1'b1;
        int_addr_o   = csr_mtvec_i;
        w_next       = S_IDLE;
      end
      S_W_MRET: begin
        hold_flag_o  = 1'b1;
        we_o         = 1'b1;
        waddr_o      = {20'h0, 12'h300};
        data_o       = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4],
                        csr_mstatus_i[7], csr_mstatus_i[2:0]};
        int_assert_o = 1'b1;
        int_addr_o   = csr_mepc_i;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_clint_ctrl.sv
// Directed bench for clint_ctrl: traps, interrupts, deferral, mret, priority, reset abort, ebreak option.
module tb_clint_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  int_flag_i;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        div_started_i;
  logic        global_int_en_i;
  logic [31:0] csr_mtvec_i;
  logic [31:0] csr_mepc_i;
  logic [31:0] csr_mstatus_i;
  logic        hold_flag_o;
  logic        we_o;
  logic [31:0] waddr_o;
  logic [31:0] data_o;
  logic        int_assert_o;
  logic [31:0] int_addr_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clint_ctrl dut (
    .clk(clk), .rst(rst), .int_flag_i(int_flag_i), .inst_i(inst_i),
    .inst_addr_i(inst_addr_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .div_started_i(div_started_i), .global_int_en_i(global_int_en_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
    .hold_flag_o(hold_flag_o), .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o),
    .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge, then let combinational outputs settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic quiet_inputs();
    inst_i        = 32'h00000013;
    int_flag_i    = 8'h00;
    jump_flag_i   = 1'b0;
    div_started_i = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".hold"}, {31'h0, hold_flag_o}, 32'h0);
    check({tag, ".we"}, {31'h0, we_o}, 32'h0);
    check({tag, ".waddr"}, waddr_o, 32'h0);
    check({tag, ".data"}, data_o, 32'h0);
    check({tag, ".assert"}, {31'h0, int_assert_o}, 32'h0);
    check({tag, ".iaddr"}, int_addr_o, 32'h0);
  endtask

  task automatic check_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic redirect, input logic [31:0] target);
    check({tag, ".hold"}, {31'h0, hold_flag_o}, 32'h1);
    check({tag, ".we"}, {31'h0, we_o}, 32'h1);
    check({tag, ".waddr"}, waddr_o, addr);
    check({tag, ".data"}, data_o, data);
    check({tag, ".assert"}, {31'h0, int_assert_o}, {31'h0, redirect});
    check({tag, ".iaddr"}, int_addr_o, target);
  endtask

  initial begin
    rst             = 1'b1;
    quiet_inputs();
    inst_addr_i     = 32'h0;
    jump_addr_i     = 32'h0;
    global_int_en_i = 1'b1;
    csr_mtvec_i     = 32'h00000200;
    csr_mepc_i      = 32'h0;
    csr_mstatus_i   = 32'h00000008;
    tick(); tick();
    check_idle("reset");
    rst = 1'b0;
    tick();
    check_idle("post_reset");

    // 1: ecall at 0x100, MIE=1 -> mstatus 0x80, mcause 11
    inst_i = 32'h00000073; inst_addr_i = 32'h100;
    settle();
    check("t1.detect_hold", {31'h0, hold_flag_o}, 32'h1);
    check("t1.detect_we", {31'h0, we_o}, 32'h0);
    tick(); quiet_inputs(); settle();
    check_write("t1.mepc", 32'h341, 32'h100, 1'b0, 32'h0);
    tick();
    check_write("t1.mstatus", 32'h300, 32'h80, 1'b0, 32'h0);
    tick();
    check_write("t1.mcause", 32'h342, 32'd11, 1'b1, 32'h200);
    tick();
    check_idle("t1.done");

    // 2: timer interrupt with jump in ex; flag change mid-sequence must not alter cause
    int_flag_i = 8'h01; jump_flag_i = 1'b1; jump_addr_i = 32'h40; inst_addr_i = 32'h300;
    settle();
    check("t2.detect_hold", {31'h0, hold_flag_o}, 32'h1);
    tick(); int_flag_i = 8'h04; jump_flag_i = 1'b0; settle();
    check_write("t2.mepc", 32'h341, 32'h40, 1'b0, 32'h0);
    tick(); int_flag_i = 8'h00;
    check_write("t2.mstatus", 32'h300, 32'h80, 1'b0, 32'h0);
    tick();
    check_write("t2.mcause", 32'h342, 32'h80000007, 1'b1, 32'h200);
    tick();
    check_idle("t2.done");

    // 3: external interrupt deferred by divide, then taken; then masked by MIE=0
    int_flag_i = 8'h04; div_started_i = 1'b1; inst_addr_i = 32'h500;
    settle();
    for (int i = 0; i < 5; i++) begin
      check("t3.div_hold", {31'h0, hold_flag_o}, 32'h0);
      check("t3.div_we", {31'h0, we_o}, 32'h0);
      tick();
    end
    div_started_i = 1'b0; settle();
    check("t3.detect_hold", {31'h0, hold_flag_o}, 32'h1);
    tick(); int_flag_i = 8'h00; settle();
    check_write("t3.mepc", 32'h341, 32'h500, 1'b0, 32'h0);
    tick(); tick();
    check_write("t3.mcause", 32'h342, 32'h8000000B, 1'b1, 32'h200);
    tick();
    check_idle("t3.done");
    global_int_en_i = 1'b0; int_flag_i = 8'h04; settle();
    for (int i = 0; i < 4; i++) begin
      check("t3.masked_hold", {31'h0, hold_flag_o}, 32'h0);
      check("t3.masked_we", {31'h0, we_o}, 32'h0);
      tick();
    end
    quiet_inputs(); global_int_en_i = 1'b1;

    // 4: mret, mepc 0x104, MPIE=1 MIE=0 -> mstatus 0x88, single held cycle
    csr_mepc_i = 32'h104; csr_mstatus_i = 32'h80; inst_i = 32'h30200073;
    settle();
    check("t4.detect_hold", {31'h0, hold_flag_o}, 32'h0);
    check("t4.detect_assert", {31'h0, int_assert_o}, 32'h0);
    tick(); quiet_inputs(); settle();
    check_write("t4.mret", 32'h300, 32'h88, 1'b1, 32'h104);
    tick();
    check_idle("t4.done");
    csr_mstatus_i = 32'h08;

    // 5a: ecall and timer flag together -> ecall wins, cause 11
    inst_i = 32'h00000073; int_flag_i = 8'h01; inst_addr_i = 32'h600;
    jump_flag_i = 1'b1; jump_addr_i = 32'h999;
    settle();
    tick(); quiet_inputs(); settle();
    check_write("t5a.mepc", 32'h341, 32'h600, 1'b0, 32'h0);
    tick(); tick();
    check_write("t5a.mcause", 32'h342, 32'd11, 1'b1, 32'h200);
    tick();
    check_idle("t5a.done");

    // 5b: reset asserted in W_MSTATUS aborts before mcause is written
    inst_i = 32'h00000073; inst_addr_i = 32'h700;
    settle();
    tick(); quiet_inputs(); settle();
    check_write("t5b.mepc", 32'h341, 32'h700, 1'b0, 32'h0);
    tick(); rst = 1'b1; settle();
    check("t5b.mstatus_we", {31'h0, we_o}, 32'h1);
    check("t5b.mstatus_addr", waddr_o, 32'h300);
    tick();
    check_idle("t5b.abort");
    rst = 1'b0;
    tick();
    check_idle("t5b.after");

    // 6: ebreak
    inst_i = 32'h00100073; inst_addr_i = 32'h800;
    settle();
`ifdef CLINT_EBREAK_EN
    check("t6.detect_hold", {31'h0, hold_flag_o}, 32'h1);
    tick(); quiet_inputs(); settle();
    check_write("t6.mepc", 32'h341, 32'h800, 1'b0, 32'h0);
    tick(); tick();
    check_write("t6.mcause", 32'h342, 32'd3, 1'b1, 32'h200);
    tick();
    check_idle("t6.done");
`else
    for (int i = 0; i < 4; i++) begin
      check_idle("t6.nop");
      tick();
    end
    quiet_inputs();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
